// File: rtl/conv_pkg.sv
// Shared constants and the loader state encoding for the conv pipeline
// (input loader, conv control stage, PE array).
package conv_pkg;

    localparam int WIDTH   = 9;
    localparam int ROW_LEN = 32;
    localparam int N_WGT   = 27;
    localparam int N_ROWS  = 32;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOAD_W   = 2'd1,
        LOAD_ROW = 2'd2,
        PRESENT  = 2'd3
    } state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/conv_pack_shift.sv
// Generic N-entry word packer: writes one WIDTH-bit word at a given index
// when enabled, and holds the packed vector otherwise.
module conv_pack_shift #(
    parameter int WIDTH = 9,
    parameter int N     = 32,
    parameter int IW    = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_en_i,
    input  logic [IW-1:0]      wr_idx_i,
    input  logic [WIDTH-1:0]   wr_data_i,
    output logic [N*WIDTH-1:0] vec_o
);

    logic [N*WIDTH-1:0] vec_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_q <= '0;
        end else if (wr_en_i) begin
            for (int k = 0; k < N; k++) begin
                if (wr_idx_i == IW'(k)) vec_q[k*WIDTH +: WIDTH] <= wr_data_i;
            end
        end
    end

    assign vec_o = vec_q;

endmodule

// File: rtl/conv_input_loader.sv
// Frame loader for the conv control stage: packs N_WGT weights, then each
// row of ROW_LEN pixels, and presents completed rows one at a time.
module conv_input_loader
    import conv_pkg::*;
#(
    parameter int WIDTH   = conv_pkg::WIDTH,
    parameter int ROW_LEN = conv_pkg::ROW_LEN,
    parameter int N_WGT   = conv_pkg::N_WGT,
    parameter int N_ROWS  = conv_pkg::N_ROWS,
    localparam int CW     = $clog2(max_int(N_WGT, ROW_LEN)),
    localparam int RW     = $clog2(N_ROWS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [WIDTH-1:0]         in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic                     en_init,
    output logic [N_WGT*WIDTH-1:0]   weight_vec,
    output logic [ROW_LEN*WIDTH-1:0] row_vec,
    output logic                     row_valid,
    input  logic                     row_ready,
    output logic [RW-1:0]            row_idx,
    output logic                     frame_done,
    output state_e                   state_dbg
);

    state_e        state_q;
    logic [CW-1:0] word_cnt_q;
    logic [RW-1:0] row_idx_q;
    logic          in_ready_q;
    logic          row_valid_q;
    logic          en_init_q;
    logic          frame_done_q;

    // Both streams transfer on the cycle valid and ready are high together;
    // ready is a registered state decode, never a function of valid.
    logic in_beat;
    logic row_hs;
    assign in_beat = in_valid && in_ready_q;
    assign row_hs  = row_valid_q && row_ready;

    logic wgt_we;
    logic pix_we;
    assign wgt_we = in_beat && (state_q == LOAD_W);
    assign pix_we = in_beat && (state_q == LOAD_ROW);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            word_cnt_q   <= '0;
            row_idx_q    <= '0;
            in_ready_q   <= 1'b0;
            row_valid_q  <= 1'b0;
            en_init_q    <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q    <= LOAD_W;
                        word_cnt_q <= '0;
                        row_idx_q  <= '0;
                        in_ready_q <= 1'b1;
                    end
                end
                LOAD_W: begin
                    if (in_beat) begin
                        if (word_cnt_q == CW'(N_WGT - 1)) begin
                            state_q    <= LOAD_ROW;
                            word_cnt_q <= '0;
                            en_init_q  <= 1'b0;
                        end else begin
                            word_cnt_q <= word_cnt_q + 1'b1;
                        end
                    end
                end
                LOAD_ROW: begin
                    if (in_beat) begin
                        if (word_cnt_q == CW'(ROW_LEN - 1)) begin
                            state_q     <= PRESENT;
                            word_cnt_q  <= '0;
                            in_ready_q  <= 1'b0;
                            row_valid_q <= 1'b1;
                        end else begin
                            word_cnt_q <= word_cnt_q + 1'b1;
                        end
                    end
                end
                PRESENT: begin
                    if (row_hs) begin
                        row_valid_q <= 1'b0;
                        if (row_idx_q == RW'(N_ROWS - 1)) begin
                            state_q      <= IDLE;
                            frame_done_q <= 1'b1;
                            en_init_q    <= 1'b1;
                        end else begin
                            state_q    <= LOAD_ROW;
                            row_idx_q  <= row_idx_q + 1'b1;
                            in_ready_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    conv_pack_shift #(.WIDTH(WIDTH), .N(N_WGT), .IW(CW)) u_wgt_pack (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (wgt_we),
        .wr_idx_i  (word_cnt_q),
        .wr_data_i (in_data),
        .vec_o     (weight_vec)
    );

    conv_pack_shift #(.WIDTH(WIDTH), .N(ROW_LEN), .IW(CW)) u_row_pack (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en_i   (pix_we),
        .wr_idx_i  (word_cnt_q),
        .wr_data_i (in_data),
        .vec_o     (row_vec)
    );

    assign in_ready   = in_ready_q;
    assign row_valid  = row_valid_q;
    assign en_init    = en_init_q;
    assign row_idx    = row_idx_q;
    assign frame_done = frame_done_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_conv_input_loader.sv
// Directed bench for conv_input_loader built with a 4-row frame.
module tb_conv_input_loader;
    import conv_pkg::*;

    localparam int W   = 9;
    localparam int RL  = 32;
    localparam int NW  = 27;
    localparam int NR  = 4;
    localparam int RWB = $clog2(NR);

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [W-1:0]      in_data;
    logic              in_valid;
    logic              in_ready;
    logic              en_init;
    logic [NW*W-1:0]   weight_vec;
    logic [RL*W-1:0]   row_vec;
    logic              row_valid;
    logic              row_ready;
    logic [RWB-1:0]    row_idx;
    logic              frame_done;
    state_e            state_dbg;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0]    exp_q[$];
    logic [RL*W-1:0] exp_row;
    logic [NW*W-1:0] exp_wgt;
    logic [RL*W-1:0] held_row;

    conv_input_loader #(.WIDTH(W), .ROW_LEN(RL), .N_WGT(NW), .N_ROWS(NR)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .en_init    (en_init),
        .weight_vec (weight_vec),
        .row_vec    (row_vec),
        .row_valid  (row_valid),
        .row_ready  (row_ready),
        .row_idx    (row_idx),
        .frame_done (frame_done),
        .state_dbg  (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [287:0] obs, input logic [287:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // drivers
    task automatic send_word(input logic [W-1:0] d);
        logic acc;
        acc      = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        for (int c = 0; c < 50 && !acc; c++) begin
            @(negedge clk);
            acc = in_ready;
            tick();
        end
        if (!acc) check("in_ready_wait", in_ready, 1'b1);
        in_valid = 1'b0;
    endtask

    task automatic send_weights(input int base);
        exp_wgt = '0;
        for (int k = 0; k < NW; k++) begin
            exp_wgt[k*W +: W] = W'(base + k);
            if (k == NW - 1) check("en_init_before_last_w", en_init, 1'b1);
            send_word(W'(base + k));
        end
    endtask

    task automatic send_row(input int base, input int step, input bit bubbles);
        for (int k = 0; k < RL; k++) begin
            if (bubbles && $urandom_range(0, 1) == 1) begin
                int gap;
                gap = $urandom_range(1, 3);
                for (int g = 0; g < gap; g++) tick();
            end
            exp_q.push_back(W'(base + step * k));
            if (k == RL - 1) check("row_valid_before_last", row_valid, 1'b0);
            send_word(W'(base + step * k));
        end
        exp_row = '0;
        for (int k = 0; k < RL; k++) exp_row[k*W +: W] = exp_q.pop_front();
    endtask

    task automatic accept_row();
        row_ready = 1'b1;
        tick();
        row_ready = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        row_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_row_valid", row_valid, 1'b0);
        check("rst_en_init", en_init, 1'b1);
        check("rst_row_vec", row_vec, '0);
        check("rst_weight_vec", weight_vec, '0);
        check("rst_state", state_dbg, IDLE);
        rst_n = 1'b1;
        tick();

        // weight load
        start = 1'b1;
        tick();
        start = 1'b0;
        @(negedge clk);
        check("lw_state", state_dbg, LOAD_W);
        check("lw_in_ready", in_ready, 1'b1);
        check("lw_en_init", en_init, 1'b1);
        tick();
        send_weights(1);
        @(negedge clk);
        check("w_en_init_low", en_init, 1'b0);
        check("w_state", state_dbg, LOAD_ROW);
        check("w_vec", weight_vec, exp_wgt);

        // row 0, continuous
        tick();
        send_row(100, 1, 1'b0);
        @(negedge clk);
        check("r0_row_valid", row_valid, 1'b1);
        check("r0_row_vec", row_vec, exp_row);
        check("r0_row_idx", row_idx, 0);
        check("r0_in_ready", in_ready, 1'b0);

        // backpressure: row held, no input taken
        held_row = row_vec;
        in_valid = 1'b1;
        in_data  = 9'h1ff;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("bp_row_vec", row_vec, held_row);
            check("bp_in_ready", in_ready, 1'b0);
            check("bp_row_valid", row_valid, 1'b1);
        end
        in_valid = 1'b0;
        tick();
        accept_row();
        @(negedge clk);
        check("hs0_state", state_dbg, LOAD_ROW);
        check("hs0_row_idx", row_idx, 1);
        check("hs0_row_valid", row_valid, 1'b0);
        check("hs0_in_ready", in_ready, 1'b1);

        // row_ready without a presented row has no effect
        tick();
        accept_row();
        @(negedge clk);
        check("stray_ready_state", state_dbg, LOAD_ROW);
        check("stray_ready_idx", row_idx, 1);

        // row 1 with random bubbles
        tick();
        send_row(200, 1, 1'b1);
        @(negedge clk);
        check("r1_row_valid", row_valid, 1'b1);
        check("r1_row_vec", row_vec, exp_row);
        check("r1_row_idx", row_idx, 1);
        tick();
        accept_row();

        // row 2
        send_row(300, 1, 1'b0);
        @(negedge clk);
        check("r2_row_vec", row_vec, exp_row);
        check("r2_row_idx", row_idx, 2);
        tick();
        accept_row();

        // last row, descending values, start during PRESENT
        send_row(511, -1, 1'b1);
        @(negedge clk);
        check("r3_row_vec", row_vec, exp_row);
        check("r3_row_idx", row_idx, 3);
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        @(negedge clk);
        check("start_in_present_state", state_dbg, PRESENT);
        check("start_in_present_valid", row_valid, 1'b1);
        check("start_in_present_en", en_init, 1'b0);
        tick();
        check("fd_before_hs", frame_done, 1'b0);
        accept_row();
        @(negedge clk);
        check("fd_pulse", frame_done, 1'b1);
        check("fd_state", state_dbg, IDLE);
        check("fd_en_init", en_init, 1'b1);
        check("fd_row_valid", row_valid, 1'b0);
        check("fd_in_ready", in_ready, 1'b0);
        check("fd_wgt_kept", weight_vec, exp_wgt);
        @(negedge clk);
        check("fd_pulse_end", frame_done, 1'b0);

        // second frame, reset in the middle of a row
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        send_weights(400);
        @(negedge clk);
        check("f2_w_vec", weight_vec, exp_wgt);
        tick();
        for (int k = 0; k < 10; k++) send_word(W'(50 + k));
        @(negedge clk);
        check("f2_mid_row_state", state_dbg, LOAD_ROW);
        #2;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_in_ready", in_ready, 1'b0);
        check("mid_rst_row_valid", row_valid, 1'b0);
        check("mid_rst_en_init", en_init, 1'b1);
        check("mid_rst_row_vec", row_vec, '0);
        check("mid_rst_wgt_vec", weight_vec, '0);
        check("mid_rst_state", state_dbg, IDLE);
        rst_n = 1'b1;
        repeat (2) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
